// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and default memory base shared by the
// MEM-stage load/store unit and its lane aligner.
package lsu_pkg;

    localparam logic [1:0]  SZ_BYTE = 2'd0;
    localparam logic [1:0]  SZ_HALF = 2'd1;
    localparam logic [1:0]  SZ_WORD = 2'd2;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1000_1000;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane select with sign/zero extension for loads,
// and byte/half lane merge into a read word for read-modify-write stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b          = word[{lane, 3'b000} +: 8];
        h          = lane[1] ? word[31:16] : word[15:0];
        load_data  = size == SZ_BYTE ? {{24{sgn & b[7]}}, b} :
                     size == SZ_HALF ? {{16{sgn & h[15]}}, h} : word;
        store_data = word;
        if (size == SZ_BYTE)
            store_data[{lane, 3'b000} +: 8] = wdata[7:0];
        else if (size == SZ_HALF)
            store_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        else
            store_data = wdata;
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: single-outstanding load/store initiator for the MEM stage.
// Define LSU_SUBWORD_EN to enable byte/half accesses (read-modify-write stores).
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          DEPTH_WORDS = 64,
    parameter int          MEM_RD_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] ReadData
);

    localparam int          CW    = $clog2(MEM_RD_LAT + 1);
    localparam logic [31:0] LIMIT = BASE_ADDR + 32'(4 * DEPTH_WORDS);

    lsu_state_t    state, state_nx;
    logic          alive, we_q, err_q;
    logic [31:0]   addr_q, wdata_q, rd_word, rdata_q;
    logic [CW-1:0] cnt;
    logic          accept, cap, rd_done;
    logic          size_bad, misaligned, out_of_range, bad;

    assign accept       = req_valid && req_ready;
    assign cap          = state == RD && cnt == CW'(MEM_RD_LAT - 1);
    assign rd_done      = state == RD && cnt == CW'(MEM_RD_LAT);
    assign out_of_range = req_addr < BASE_ADDR || req_addr >= LIMIT;
    assign bad          = size_bad || misaligned || out_of_range;

`ifdef LSU_SUBWORD_EN
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [31:0] load_data, store_data;

    assign size_bad   = req_size == 2'd3;
    assign misaligned = (req_size == SZ_HALF && req_addr[0]) ||
                        (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

    lsu_align u_align (
        .word       (rd_word),
        .lane       (addr_q[1:0]),
        .size       (size_q),
        .sgn        (sgn_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            size_q <= SZ_WORD;
            sgn_q  <= 1'b0;
        end else if (accept) begin
            size_q <= req_size;
            sgn_q  <= req_signed;
        end
    end
`else
    logic unused_ok;

    assign size_bad   = req_size != SZ_WORD;
    assign misaligned = req_addr[1:0] != 2'b00;
    assign unused_ok  = ^{req_signed, we_q, addr_q[1:0]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Errors pass through WR with the strobe gated so the response lands one edge after acceptance.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !accept ? IDLE :
                                (bad || (req_we && req_size == SZ_WORD)) ? WR : RD;
`ifdef LSU_SUBWORD_EN
            RD:      state_nx = !rd_done ? RD : we_q ? WR : RESP;
`else
            RD:      state_nx = rd_done ? RESP : RD;
`endif
            WR:      state_nx = RESP;
            RESP:    state_nx = resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
        req_ready  = state == IDLE && alive;
        MemRead    = state == RD && !rd_done;
        MemWrite   = state == WR && !err_q;
        resp_valid = state == RESP;
        resp_err   = state == RESP && err_q;
        Address    = {addr_q[31:2], 2'b00};
        WriteData  = wdata_q;
        resp_rdata = rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_word <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            alive <= 1'b1;
            if (accept) begin
                we_q    <= req_we;
                err_q   <= bad;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
                cnt     <= '0;
            end
            if (state == RD && !rd_done)
                cnt <= cnt + 1'b1;
            if (cap)
                rd_word <= ReadData;
            if (rd_done) begin
`ifdef LSU_SUBWORD_EN
                if (we_q)
                    wdata_q <= store_data;
                else
                    rdata_q <= load_data;
`else
                rdata_q <= rd_word;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed bench for mem_stage_lsu against a 64-word data memory
// model with combinational read; sub-word scenarios follow LSU_SUBWORD_EN.
module tb_mem_stage_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, resp_ready = 1'b1;
    logic [1:0]  req_size = SZ_WORD;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, MemRead, MemWrite;
    logic [31:0] resp_rdata, Address, WriteData, ReadData;

    logic [31:0] mem [0:63];
    logic [31:0] last_wd = '0;
    bit          inited, both_seen;
    int          wr_cnt, rd_cnt, n_chk, n_fail;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .Address(Address),
        .WriteData(WriteData), .MemRead(MemRead), .MemWrite(MemWrite),
        .ReadData(ReadData)
    );

    assign ReadData = MemRead ? mem[Address[7:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (!inited) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
            mem[4] <= 32'h1122_3344;
            inited <= 1'b1;
        end else if (MemWrite) begin
            mem[Address[7:2]] <= WriteData;
            last_wd           <= WriteData;
        end
        if (MemWrite) wr_cnt <= wr_cnt + 1;
        if (MemRead) rd_cnt <= rd_cnt + 1;
        if (MemRead && MemWrite) both_seen <= 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one request and completes the response; lat counts edges from acceptance to resp_valid.
    task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nwr, output int nrd);
        int w0, r0;
        @(negedge clk);
        w0 = wr_cnt; r0 = rd_cnt;
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata; er = resp_err;
        @(posedge clk); #1;
        nwr = wr_cnt - w0; nrd = rd_cnt - r0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if ({req_ready, resp_valid, resp_err, MemRead, MemWrite} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {req_ready, resp_valid, resp_err, MemRead, MemWrite});
        end
        n_chk++; if ({Address, WriteData, resp_rdata} !== 96'b0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h want zeros", Address, WriteData, resp_rdata);
        end
        rst = 1'b1;
        #1;
        n_chk++; if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_early: got %b want 0", req_ready);
        end
        @(negedge clk);
        n_chk++; if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_after: got %b want 1", req_ready);
        end
    endtask

    task automatic test_word_store_load;
        int lat, nw, nr; logic [31:0] rd; logic er;
        xact(1'b1, SZ_WORD, 1'b0, 32'h1000_101C, 32'h00AB_CDEF, lat, rd, er, nw, nr);
        n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL sw_latency: got %0d want 1", lat); end
        n_chk++; if (nw !== 1 || nr !== 0) begin n_fail++; $display("FAIL sw_strobes: got wr=%0d rd=%0d want wr=1 rd=0", nw, nr); end
        n_chk++; if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL sw_resp: got err=%b rdata=%h want 0 0", er, rd); end
        n_chk++; if (mem[7] !== 32'h00AB_CDEF) begin n_fail++; $display("FAIL sw_mem: got %h want 00abcdef", mem[7]); end
        xact(1'b0, SZ_WORD, 1'b0, 32'h1000_101C, 32'h0, lat, rd, er, nw, nr);
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d want 2", lat); end
        n_chk++; if (rd !== 32'h00AB_CDEF || er !== 1'b0) begin n_fail++; $display("FAIL lw_data: got %h err=%b want 00abcdef err=0", rd, er); end
        n_chk++; if (nw !== 0 || nr !== 1) begin n_fail++; $display("FAIL lw_strobes: got wr=%0d rd=%0d want wr=0 rd=1", nw, nr); end
    endtask

`ifdef LSU_SUBWORD_EN
    task automatic test_subword;
        int lat, nw, nr; logic [31:0] rd; logic er;
        xact(1'b1, SZ_BYTE, 1'b0, 32'h1000_1011, 32'h0000_00AA, lat, rd, er, nw, nr);
        n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d want 3", lat); end
        n_chk++; if (nw !== 1 || nr !== 1) begin n_fail++; $display("FAIL sb_strobes: got wr=%0d rd=%0d want 1 1", nw, nr); end
        n_chk++; if (last_wd !== 32'h1122_AA44) begin n_fail++; $display("FAIL sb_wdata: got %h want 1122aa44", last_wd); end
        n_chk++; if (mem[4] !== 32'h1122_AA44) begin n_fail++; $display("FAIL sb_mem: got %h want 1122aa44", mem[4]); end
        xact(1'b0, SZ_BYTE, 1'b1, 32'h1000_1011, 32'h0, lat, rd, er, nw, nr);
        n_chk++; if (rd !== 32'hFFFF_FFAA || lat !== 2) begin n_fail++; $display("FAIL lb: got %h lat=%0d want ffffffaa lat=2", rd, lat); end
        xact(1'b0, SZ_BYTE, 1'b0, 32'h1000_1011, 32'h0, lat, rd, er, nw, nr);
        n_chk++; if (rd !== 32'h0000_00AA) begin n_fail++; $display("FAIL lbu: got %h want 000000aa", rd); end
        xact(1'b0, SZ_HALF, 1'b1, 32'h1000_1012, 32'h0, lat, rd, er, nw, nr);
        n_chk++; if (rd !== 32'h0000_1122) begin n_fail++; $display("FAIL lh: got %h want 00001122", rd); end
        xact(1'b0, SZ_HALF, 1'b0, 32'h1000_1011, 32'h0, lat, rd, er, nw, nr);
        n_chk++; if (er !== 1'b1 || lat !== 1 || nr !== 0) begin n_fail++; $display("FAIL lh_misaligned: got err=%b lat=%0d rd=%0d want 1 1 0", er, lat, nr); end
    endtask
`else
    task automatic test_subword;
        int lat, nw, nr; logic [31:0] rd; logic er;
        xact(1'b1, SZ_BYTE, 1'b0, 32'h1000_1011, 32'h0000_00AA, lat, rd, er, nw, nr);
        n_chk++; if (er !== 1'b1 || lat !== 1 || nw + nr !== 0) begin n_fail++; $display("FAIL sb_disabled: got err=%b lat=%0d strobes=%0d want 1 1 0", er, lat, nw + nr); end
        xact(1'b0, SZ_HALF, 1'b1, 32'h1000_1012, 32'h0, lat, rd, er, nw, nr);
        n_chk++; if (er !== 1'b1 || lat !== 1 || nw + nr !== 0 || rd !== 32'h0) begin n_fail++; $display("FAIL lh_disabled: got err=%b lat=%0d strobes=%0d rd=%h want 1 1 0 0", er, lat, nw + nr, rd); end
        n_chk++; if (mem[4] !== 32'h1122_3344) begin n_fail++; $display("FAIL disabled_mem: got %h want 11223344", mem[4]); end
    endtask
`endif

    localparam int          NE = 6;
    localparam logic [31:0] TA [NE] = '{32'h1000_1002, 32'h1000_1100, 32'h1000_1010, 32'h1000_0FFC, 32'h1000_10FC, 32'h1000_1100};
    localparam logic [1:0]  TS [NE] = '{SZ_WORD, SZ_WORD, 2'd3, SZ_WORD, SZ_WORD, SZ_WORD};
    localparam logic        TW [NE] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic        TE [NE] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic [31:0] TR [NE] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hC0DE_003F, 32'h0};

    task automatic test_errors;
        int lat, nw, nr; logic [31:0] rd; logic er;
        for (int k = 0; k < NE; k++) begin
            xact(TW[k], TS[k], 1'b0, TA[k], 32'h5A5A_5A5A, lat, rd, er, nw, nr);
            n_chk++; if (er !== TE[k]) begin n_fail++; $display("FAIL err_flag[%0d]: got %b want %b", k, er, TE[k]); end
            n_chk++; if (rd !== TR[k] || lat !== (TE[k] ? 1 : 2)) begin n_fail++; $display("FAIL err_resp[%0d]: got %h lat=%0d want %h", k, rd, lat, TR[k]); end
            n_chk++; if (nw !== 0 || nr !== (TE[k] ? 0 : 1)) begin n_fail++; $display("FAIL err_strobes[%0d]: got wr=%0d rd=%0d", k, nw, nr); end
        end
    endtask

    task automatic test_backpressure;
        int waitc;
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_addr = 32'h1000_101C;
        @(posedge clk); #1;
        req_valid = 1'b0;
        waitc = 0;
        while (!resp_valid && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        n_chk++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h00AB_CDEF) begin n_fail++; $display("FAIL bp_first: got valid=%b rdata=%h want 1 00abcdef", resp_valid, resp_rdata); end
        repeat (4) begin
            @(posedge clk); #1;
            n_chk++; if ({resp_valid, req_ready, MemRead, MemWrite} !== 4'b1000) begin n_fail++; $display("FAIL bp_hold_ctrl: got %b want 1000", {resp_valid, req_ready, MemRead, MemWrite}); end
            n_chk++; if (resp_rdata !== 32'h00AB_CDEF) begin n_fail++; $display("FAIL bp_hold_data: got %h want 00abcdef", resp_rdata); end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got valid=%b ready=%b want 0 1", resp_valid, req_ready); end
    endtask

    task automatic test_reset_mid_op;
        int w0, lat, nw, nr; logic [31:0] rd, want; logic er;
`ifdef LSU_SUBWORD_EN
        logic [1:0] sz = SZ_HALF; logic we = 1'b1; logic [31:0] a = 32'h1000_1010;
        want = 32'h1122_AA44;
`else
        logic [1:0] sz = SZ_WORD; logic we = 1'b0; logic [31:0] a = 32'h1000_101C;
        want = 32'h00AB_CDEF;
`endif
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = 32'h0000_5555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_chk++; if (MemRead !== 1'b1) begin n_fail++; $display("FAIL rmw_in_read: got MemRead=%b want 1", MemRead); end
        rst = 1'b0;
        #1;
        n_chk++; if ({MemRead, MemWrite, req_ready, resp_valid} !== 4'b0 || Address !== 32'h0) begin n_fail++; $display("FAIL rmw_reset_outs: got %b addr=%h want 0000 0", {MemRead, MemWrite, req_ready, resp_valid}, Address); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (wr_cnt !== w0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_no_write: got writes=%0d valid=%b want 0 0", wr_cnt - w0, resp_valid); end
        xact(1'b0, SZ_WORD, 1'b0, a, 32'h0, lat, rd, er, nw, nr);
        n_chk++; if (rd !== want || er !== 1'b0) begin n_fail++; $display("FAIL rmw_readback: got %h want %h", rd, want); end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_subword();
        test_errors();
        test_backpressure();
        test_reset_mid_op();
        n_chk++; if (both_seen) begin n_fail++; $display("FAIL strobe_overlap: got 1 want 0"); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store initiator for the MEM stage of the pipelined MIPS core. Accepts one load or store request at a time from the pipeline over a valid/ready handshake, drives the word-addressed data memory (Address, WriteData, MemRead, MemWrite, ReadData), and returns the load data or a store completion over a valid/ready response channel. It handles sub-word accesses by lane extraction on loads and read-modify-write on stores, because the data memory has no byte enables. It also flags misaligned and out-of-range accesses.

## Interface
- BASE_ADDR, 32'h1000_1000: byte address of data-memory word 0.
- DEPTH_WORDS, 64: number of 32-bit words in the data memory.
- MEM_RD_LAT, 1: cycles from first MemRead cycle to valid ReadData (≥1).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_signed  in  1  sign-extend sub-word load (lb/lh) vs zero-extend (lbu/lhu).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  pipeline accepts response.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range, or illegal size.
- Address  out  32  word-aligned byte address to memory.
- WriteData  out  32  write word to memory.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe, one cycle per write.
- ReadData  in  32  memory read word.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready the request is latched and checked.
  - Error if req_size==3, if the address is not aligned (half: addr[0]≠0; word: addr[1:0]≠0), or if the address is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
  - Error → RESP with resp_err=1; no memory strobe is issued.
  - Load, or sub-word store → RD.
  - Word store → WR.
- RD: MemRead=1. Address={addr[31:2],2'b00} is held stable for MEM_RD_LAT cycles, then ReadData is captured.
  - Load → RESP. resp_rdata = the selected lane, little-endian by addr[1:0], extended per req_signed.
  - Sub-word store → WR.
- WR: MemWrite=1 for exactly one cycle.
  - Word store: WriteData=req_wdata.
  - Sub-word store: WriteData = captured word with the addressed byte/half lane replaced. → RESP.
- RESP: resp_valid=1 and outputs are held until resp_ready. Then → IDLE. req_ready stays 0 until IDLE.
- MemRead and MemWrite are never high in the same cycle.

## Timing
- Acceptance edge is E0.
- Error: resp_valid rises at E1.
- Word store: MemWrite high E0→E1; resp_valid rises at E1.
- Load: MemRead high E0→E(MEM_RD_LAT); ReadData sampled at E(MEM_RD_LAT); resp_valid rises at E(MEM_RD_LAT+1).
- Sub-word store: read as for a load; MemWrite high E(MEM_RD_LAT+1)→E(MEM_RD_LAT+2); resp_valid rises at E(MEM_RD_LAT+2).
- Back-to-back: the next request is accepted no earlier than the edge after the resp_valid&&resp_ready edge. Throughput is at most one access per latency+2 cycles.
- Reset (rst=0, any time, mid-operation included):
  - state → IDLE.
  - req_ready=0 while asserted, 1 the cycle after release.
  - resp_valid, resp_err, MemRead, MemWrite = 0.
  - Address, WriteData, resp_rdata = 0.
  - An in-flight read-modify-write is abandoned with no write issued.

## Configuration
- LSU_SUBWORD_EN defined: byte and half accesses are supported as above.
- LSU_SUBWORD_EN undefined:
  - Only req_size==2 is legal. Byte and half requests return resp_err=1 at E1 with no memory access.
  - The lane extract/merge logic and the RD→WR path are not compiled.

## Structure
- Package lsu_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum, and the default BASE_ADDR.
- Sub-module lsu_align (combinational): load lane select plus sign/zero extension, and store lane merge. Instantiated only under LSU_SUBWORD_EN.

## Test plan
- Reset: hold rst=0 for 3 cycles, then release → all outputs 0 during reset; req_ready=1 one cycle after release; no strobes.
- Word store then word load: store 0x00ABCDEF to 0x1000101C → one MemWrite cycle and resp_valid at E1. Load 0x1000101C → resp_rdata=0x00ABCDEF at E2 (MEM_RD_LAT=1).
- Sub-word (LSU_SUBWORD_EN): word at 0x10001010 holds 0x11223344.
  - sb 0xAA to 0x10001011 → WriteData=0x1122AA44.
  - lb from 0x10001011 → 0xFFFFFFAA.
  - lbu from 0x10001011 → 0x000000AA.
  - lh from 0x10001012 → 0x00001122.
- Errors, each giving resp_err=1 at E1 and no MemRead/MemWrite:
  - word load at 0x10001002.
  - access at 0x10001100 (out of range).
  - req_size=3.
- Backpressure: hold resp_ready=0 for 4 cycles after a load → resp_valid and resp_rdata stable, req_ready=0, MemRead=0.
- Reset mid read-modify-write: assert rst during RD of an sh → no MemWrite is ever issued; a later load of the word returns the original value.
